// File: rtl/cmd_pkg.sv
// cmd_pkg: shared constants and state encoding for the /CMD save path
package cmd_pkg;
    localparam logic [7:0] CMD_BLK_LOAD = 8'h01;
    localparam logic [7:0] CMD_BLK_XFER = 8'h02;
    localparam logic [7:0] CMD_BLK_EOF  = 8'h00;
    localparam int         MAX_BLK      = 256;

    typedef enum logic [3:0] {
        IDLE, B_TYPE, B_LEN, B_LSB, B_MSB, RD_REQ, RD_WAIT, B_DATA,
        T_TYPE, T_LEN, T_LSB, T_MSB, EOF, DONE
    } cmd_save_state_t;
endpackage

// File: rtl/cmd_block_sizer.sv
// cmd_block_sizer: data byte count and LEN byte of the next load block
module cmd_block_sizer
    import cmd_pkg::*;
(
    input  logic [16:0] rem,
    output logic [8:0]  n,
    output logic [7:0]  len
);
    // 255 bytes is split 254+1 so LEN never encodes 0x01
    always_comb begin
        n   = rem >= 17'(MAX_BLK) ? 9'(MAX_BLK) : rem == 17'd255 ? 9'd254 : rem[8:0];
        len = n[7:0] + 8'd2;
    end
endmodule

// File: rtl/cmd_saver.sv
// cmd_saver: serializes a memory range into a TRS-80 /CMD load-module stream
module cmd_saver
    import cmd_pkg::*;
#(
    parameter int ADDR   = 16,
    parameter int DATA   = 8,
    parameter int RD_LAT = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [ADDR-1:0] start_addr,
    input  logic [ADDR-1:0] end_addr,
    input  logic [ADDR-1:0] exec_addr,
    input  logic            exec_enable,
    output logic            mem_rd,
    output logic [ADDR-1:0] mem_addr,
    input  logic [DATA-1:0] mem_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_data,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam logic [1:0] LAT = 2'(RD_LAT);

    cmd_save_state_t state_q, state_d;
    logic [ADDR-1:0] cur_q, cur_d, exec_q, exec_d;
    logic [ADDR:0]   rem_q, rem_d;
    logic [8:0]      n_q, n_d, blk_n;
    logic [7:0]      blk_len;
    logic [1:0]      wait_q, wait_d;
    logic            exen_q, exen_d, valid_q, valid_d, err_q, err_d;
    logic [DATA-1:0] data_q, data_d;
    logic            acc, bad;

    cmd_block_sizer u_sizer (.rem(rem_q), .n(blk_n), .len(blk_len));

    always_comb begin
        acc     = valid_q & out_ready;
        bad     = start_addr > end_addr;
        state_d = state_q;
        cur_d   = cur_q;
        exec_d  = exec_q;
        exen_d  = exen_q;
        rem_d   = rem_q;
        n_d     = n_q;
        wait_d  = wait_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                cur_d   = start_addr;
                exec_d  = exec_addr;
                exen_d  = exec_enable;
                rem_d   = {1'b0, end_addr} - {1'b0, start_addr} + (ADDR+1)'(1);
                err_d   = bad;
                state_d = !bad ? B_TYPE : exec_enable ? T_TYPE : EOF;
            end
            B_TYPE: if (acc) begin
                n_d     = blk_n;
                state_d = B_LEN;
            end
            B_LEN:  if (acc) state_d = B_LSB;
            B_LSB:  if (acc) state_d = B_MSB;
            B_MSB:  if (acc) state_d = RD_REQ;
            RD_REQ: begin
                wait_d  = 2'd1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                wait_d  = wait_q + 2'd1;
                state_d = wait_q == LAT ? B_DATA : RD_WAIT;
            end
            B_DATA: if (acc) begin
                cur_d   = cur_q + ADDR'(1);
                rem_d   = rem_q - (ADDR+1)'(1);
                n_d     = n_q - 9'd1;
                state_d = n_q != 9'd1 ? RD_REQ : rem_q != (ADDR+1)'(1) ? B_TYPE : exen_q ? T_TYPE : EOF;
            end
            T_TYPE: if (acc) state_d = T_LEN;
            T_LEN:  if (acc) state_d = T_LSB;
            T_LSB:  if (acc) state_d = T_MSB;
            T_MSB, EOF: if (acc) state_d = DONE;
            default: state_d = IDLE;
        endcase
        valid_d = state_d inside {B_TYPE, B_LEN, B_LSB, B_MSB, B_DATA, T_TYPE, T_LEN, T_LSB, T_MSB, EOF};
        // every emitting state is entered once per byte: load on entry, hold while stalled
        data_d = state_d == state_q ? data_q
               : state_d == B_TYPE ? CMD_BLK_LOAD
               : state_d == B_LEN  ? blk_len
               : state_d == B_LSB  ? cur_q[7:0]
               : state_d == B_MSB  ? cur_q[15:8]
               : state_d == B_DATA ? mem_data
               : state_d == T_TYPE || state_d == T_LEN ? CMD_BLK_XFER
               : state_d == T_LSB  ? exec_q[7:0]
               : state_d == T_MSB  ? exec_q[15:8]
               : state_d == EOF    ? CMD_BLK_EOF : data_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            exec_q  <= '0;
            exen_q  <= 1'b0;
            rem_q   <= '0;
            n_q     <= '0;
            wait_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            exec_q  <= exec_d;
            exen_q  <= exen_d;
            rem_q   <= rem_d;
            n_q     <= n_d;
            wait_q  <= wait_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign mem_rd    = state_q == RD_REQ;
    assign mem_addr  = cur_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = state_q != IDLE && state_q != DONE;
    assign done      = state_q == DONE;
    assign err       = err_q;
endmodule

// File: tb/tb_cmd_saver.sv
// tb_cmd_saver: randomized /CMD save stream checked against a byte-queue model
module tb_cmd_saver;
    localparam int LAT = 3;

    logic        clock = 0, reset_n = 0, start = 0, exec_enable = 0, out_ready = 1;
    logic [15:0] start_addr = 0, end_addr = 0, exec_addr = 0;
    logic        mem_rd, out_valid, busy, done, err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data, out_data;

    logic [7:0]  mem [65536];
    logic [15:0] pipe_a [LAT];
    logic [LAT-1:0] pipe_v = '0;

    typedef struct { logic [7:0] b; bit d; } ent_t;
    ent_t        exp_q [$];
    logic [15:0] addr_q [$];
    ent_t        e;

    int checks = 0, passed = 0, done_cnt = 0, ready_mode = 0, since_rd = -1;
    bit mon = 0, stall = 0, want_rd = 0, want_done = 0, nrd, ndone;
    logic [7:0] stall_b;
    logic [7:0] t1 [11] = '{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h52};

    cmd_saver #(.ADDR(16), .DATA(8), .RD_LAT(LAT)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .start_addr(start_addr), .end_addr(end_addr), .exec_addr(exec_addr), .exec_enable(exec_enable),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    // read data is only correct exactly LAT cycles after the strobe; otherwise it is inverted
    always @(posedge clock) begin
        pipe_v    <= {pipe_v[LAT-2:0], mem_rd};
        pipe_a[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign mem_data = pipe_v[LAT-1] ? mem[pipe_a[LAT-1]] : ~mem[pipe_a[LAT-1]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, req);
    endtask

    task automatic push(input int v, input bit d);
        exp_q.push_back('{8'(v), d});
    endtask

    task automatic build(input logic [15:0] s, input logic [15:0] en_a, input logic [15:0] x, input bit en);
        int rem, cur, n;
        exp_q.delete();
        addr_q.delete();
        if (s <= en_a) begin
            rem = int'(en_a) - int'(s) + 1;
            cur = int'(s);
            while (rem > 0) begin
                n = rem >= 256 ? 256 : rem == 255 ? 254 : rem;
                push(1, 0); push((n + 2) % 256, 0); push(cur % 256, 0); push(cur / 256, 0);
                for (int k = 0; k < n; k++) begin
                    push(int'(mem[cur + k]), 1);
                    addr_q.push_back(16'(cur + k));
                end
                cur += n;
                rem -= n;
            end
        end
        if (en) begin
            push(2, 0); push(2, 0); push(int'(x[7:0]), 0); push(int'(x[15:8]), 0);
        end else push(0, 0);
    endtask

    task automatic run(input logic [15:0] s, input logic [15:0] en_a, input logic [15:0] x, input bit en, input int mode);
        int c0;
        build(s, en_a, x, en);
        c0 = done_cnt;
        mon = 1;
        ready_mode = mode;
        @(posedge clock); #1;
        start_addr = s; end_addr = en_a; exec_addr = x; exec_enable = en; start = 1;
        @(posedge clock); #1;
        start = 0; start_addr = 16'($urandom); end_addr = 16'($urandom); exec_addr = 16'($urandom); exec_enable = 1'($urandom);
        @(negedge clock);
        chk("first_valid", out_valid, 1);
        chk("first_byte", out_data, s <= en_a ? 8'h01 : en ? 8'h02 : 8'h00);
        chk("err_pulse", err, s > en_a);
        chk("busy", busy, 1);
        @(negedge clock);
        chk("err_clear", err, 0);
        if (s <= en_a) begin
            @(posedge clock); #1;
            start_addr = 16'h0000; end_addr = 16'hFFFF; start = 1;
            @(posedge clock); #1;
            start = 0;
        end
        for (int k = 0; k < 20000 && done_cnt == c0; k++) @(negedge clock);
        chk("done_seen", done_cnt - c0, 1);
        #1;
        chk("bytes_left", exp_q.size(), 0);
        chk("addrs_left", addr_q.size(), 0);
    endtask

    initial forever begin
        @(posedge clock); #1;
        out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    initial forever begin
        @(negedge clock);
        if (!mon) begin
            stall = 0; since_rd = -1; want_rd = 0; want_done = 0;
        end else begin
            chk("done", done, want_done);
            if (done) done_cnt++;
            if (want_rd) chk("rd_pace", mem_rd, 1);
            if (want_done) chk("busy_at_done", busy, 0);
            nrd = 0;
            ndone = 0;
            if (mem_rd) begin
                if (addr_q.size() == 0) chk("rd_extra", mem_rd, 0);
                else chk("rd_addr", mem_addr, addr_q.pop_front());
                since_rd = 0;
            end else if (since_rd >= 0) since_rd++;
            if (since_rd == LAT) chk("data_early", out_valid, 0);
            if (since_rd == LAT + 1) begin
                chk("data_late", out_valid, 1);
                since_rd = -1;
            end
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, stall_b);
            end
            stall = out_valid && !out_ready;
            stall_b = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("byte_extra", out_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("byte", out_data, e.b);
                    ndone = exp_q.size() == 0;
                    nrd = !ndone && exp_q[0].d;
                end
            end
            want_rd = nrd;
            want_done = ndone;
        end
    end

    initial begin
        int len;
        logic [15:0] s;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h5200] = 8'hAA; mem[16'h5201] = 8'hBB; mem[16'h5202] = 8'hCC;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0); chk("rst_rd", mem_rd, 0);
        chk("rst_addr", mem_addr, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
        @(posedge clock); #1 reset_n = 1;

        build(16'h5200, 16'h5202, 16'h5200, 1);
        chk("model_t1_size", exp_q.size(), 11);
        for (int i = 0; i < 11; i++) chk("model_t1", exp_q[i].b, t1[i]);
        build(16'h6000, 16'h60FF, 16'h0, 0);
        chk("model_t2_size", exp_q.size(), 261);
        chk("model_t2_len", exp_q[1].b, 8'h02);
        chk("model_t2_eof", exp_q[260].b, 8'h00);
        build(16'h7000, 16'h70FE, 16'h0, 0);
        chk("model_t3_size", exp_q.size(), 264);
        chk("model_t3_len0", exp_q[1].b, 8'h00);
        chk("model_t3_h0", exp_q[258].b, 8'h01);
        chk("model_t3_h1", exp_q[259].b, 8'h03);
        chk("model_t3_h2", exp_q[260].b, 8'hFE);
        chk("model_t3_h3", exp_q[261].b, 8'h70);
        build(16'h8000, 16'h7FFF, 16'h0, 0);
        chk("model_err_size", exp_q.size(), 1);

        run(16'h5200, 16'h5202, 16'h5200, 1, 0);
        run(16'h6000, 16'h60FF, 16'h0000, 0, 0);
        run(16'h7000, 16'h70FE, 16'h1234, 0, 1);
        run(16'hFF00, 16'hFFFF, 16'hFF00, 1, 0);
        run(16'hFF00, 16'hFFFF, 16'hFF00, 1, 1);
        run(16'h8000, 16'h7FFF, 16'h0000, 0, 1);
        run(16'h9000, 16'h1000, 16'hABCD, 1, 1);
        run(16'h0000, 16'h0000, 16'h0102, 0, 1);
        for (int r = 0; r < 5; r++) begin
            len = $urandom_range(1, 600);
            s = 16'($urandom_range(0, 65536 - len));
            run(s, 16'(int'(s) + len - 1), 16'($urandom), 1'($urandom), $urandom_range(0, 1));
        end

        build(16'h3000, 16'h3007, 16'h0, 0);
        mon = 1;
        ready_mode = 0;
        @(posedge clock); #1;
        start_addr = 16'h3000; end_addr = 16'h3007; exec_enable = 0; start = 1;
        @(posedge clock); #1 start = 0;
        for (int k = 0; k < 50 && !mem_rd; k++) @(negedge clock);
        #1 ready_mode = 2;
        for (int k = 0; k < 50 && !out_valid; k++) @(negedge clock);
        chk("stall_reached", out_valid, 1);
        @(negedge clock);
        @(negedge clock);
        #1 mon = 0;
        reset_n = 0;
        @(negedge clock);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd", mem_rd, 0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clock); #1 reset_n = 1;
        run(16'h4444, 16'h4444, 16'h1234, 1, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/cmd_saver.md
# cmd_saver

Serializes a memory range into a TRS-80 /CMD byte stream: load-module blocks, then a transfer-address or EOF trailer. It is the save-side counterpart of the /CMD download path. It sits between the system RAM read port and the ioctl upload path, and produces a stream the core's own /CMD loader re-ingests byte-for-byte.

## Interface
Parameters:
- `ADDR`, 16, memory address width
- `DATA`, 8, data / stream byte width
- `RD_LAT`, 1, memory read latency in clocks (1..3)

Ports:
- `clock`  in  1  single clock
- `reset_n`  in  1  reset: synchronous, active-low
- `start`  in  1  one-cycle request; sampled only in IDLE
- `start_addr`  in  ADDR  first byte address; latched on `start`
- `end_addr`  in  ADDR  last byte address, inclusive; latched on `start`
- `exec_addr`  in  ADDR  transfer address; latched on `start`
- `exec_enable`  in  1  1 = emit type-02 trailer, 0 = emit 0x00 EOF; latched on `start`
- `mem_rd`  out  1  one-cycle read strobe
- `mem_addr`  out  ADDR  read address, valid with `mem_rd`
- `mem_data`  in  DATA  read data, valid exactly `RD_LAT` clocks after `mem_rd`
- `out_valid`  out  1  `out_data` holds a stream byte
- `out_ready`  in  1  consumer accepts byte when `out_valid & out_ready`
- `out_data`  out  DATA  stream byte
- `busy`  out  1  high from cycle after `start` until DONE
- `done`  out  1  one-cycle pulse after last byte accepted
- `err`  out  1  one-cycle pulse: `start_addr > end_addr`

## Operation
- Remaining count `rem` is 17 bits: `end_addr - start_addr + 1`, range 1..65536. `cur` is the ADDR-bit read pointer.
- Block size `n`:
  - `rem >= 256` gives 256.
  - `rem == 255` gives 254. The remaining 1 byte goes in the next block.
  - Otherwise `n = rem`.
  - A 255-byte block is never emitted.
- Data block: bytes are `0x01`, `LEN = (n+2) mod 256`, `cur[7:0]`, `cur[15:8]`, then `n` data bytes.
  - n=256 gives LEN 0x02.
  - n=254 gives LEN 0x00.
  - n=1 gives LEN 0x03.
- Trailer:
  - `exec_enable=1`: `0x02 0x02 lo hi` of `exec_addr`.
  - `exec_enable=0`: a single `0x00`.
- States: IDLE, B_TYPE, B_LEN, B_LSB, B_MSB, RD_REQ, RD_WAIT, B_DATA, T_TYPE, T_LEN, T_LSB, T_MSB, EOF, DONE.
- Transitions:
  - IDLE→B_TYPE on `start` with a valid range.
  - IDLE→T_TYPE/EOF on `start` with `start_addr > end_addr`. Pulse `err`; no data blocks are emitted.
  - Each header state advances on accept.
  - B_MSB→RD_REQ.
  - RD_REQ: assert `mem_rd`, `mem_addr=cur`, then go to RD_WAIT. RD_WAIT counts `RD_LAT`, captures `mem_data`, then goes to B_DATA.
  - B_DATA on accept: `cur++` (wraps at 0xFFFF→0x0000 only after the last byte), `rem--`, `n--`.
    - If `n` becomes 0 and `rem` is 0, go to trailer.
    - If `n` becomes 0 and `rem` is nonzero, go to B_TYPE.
    - Otherwise go to RD_REQ.
  - Trailer last byte accepted → DONE → IDLE.
- `start` while busy is ignored.
- Reset mid-operation:
  - Next cycle: IDLE, `out_valid=0`, `mem_rd=0`.
  - All latched parameters are discarded.
  - An in-flight read result is dropped.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `mem_rd=0`, `mem_addr=0`, `busy=0`, `done=0`, `err=0`.
- `start` at cycle t gives `out_valid=1`, `out_data=0x01` at t+1.
- `out_data` is registered and stable while `out_valid & ~out_ready`. `out_valid` never drops without an accept.
- After a header byte is accepted, the next header byte is valid the following cycle (one byte per cycle at full ready).
- Data byte pacing:
  - `mem_rd` is asserted the cycle after B_MSB accept or the previous data-byte accept.
  - `out_valid` rises `RD_LAT+1` cycles after `mem_rd`.
  - Sustained rate is one data byte per `RD_LAT+2` cycles.
- `done` pulses the cycle after the final accept; `busy` falls in the same cycle.

## Structure
- Shared package `cmd_pkg`:
  - constants `CMD_BLK_LOAD=8'h01`, `CMD_BLK_XFER=8'h02`, `CMD_BLK_EOF=8'h00`
  - `MAX_BLK=256`
  - state enum `cmd_save_state_t`
- One sub-module is natural: `cmd_block_sizer`, combinational `rem` (17b) → `n` (9b) and `LEN` byte, including the 255→254 split.

## Test plan
- Range 0x5200–0x5202 holding AA BB CC, exec 0x5200 enabled → `01 05 00 52 AA BB CC 02 02 00 52`, then `done`.
- Range 0x6000–0x60FF, exec disabled → `01 02 00 60` + 256 bytes + `00`.
- Range 0x7000–0x70FE (255 bytes) → `01 00 00 70` + 254 bytes, then `01 03 FE 70` + 1 byte, then trailer.
- Range 0xFF00–0xFFFF with random `out_ready` throttling and `RD_LAT=3` → byte stream identical to the unthrottled run.
  - `out_data` stable while stalled.
  - Memory addresses requested are exactly 0xFF00..0xFFFF, each once.
- `start_addr=0x8000`, `end_addr=0x7FFF`, exec disabled → `err` pulse, stream is only `00`, then `done`.
- `reset_n` low during a B_DATA stall →
  - next cycle `out_valid=0`, `busy=0`;
  - a following `start` of 1 byte produces a correct complete stream.
